// File: rtl/dp_sink_aux_responder.sv
// Sink-side AUX responder: decodes framed native read/write requests against a
// small DPCD register window and returns a framed ACK/NACK/DEFER reply.
module dp_sink_aux_responder #(
  parameter logic [19:0] BASE_ADDR   = 20'h00000,
  parameter int          DEPTH       = 16,
  parameter int          REPLY_DELAY = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_vld,
  input  logic       rx_frame,
  input  logic       defer_req,
  output logic [7:0] tx_data,
  output logic       tx_vld,
  output logic       tx_frame,
  output logic       busy,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [20:0] WIN_LAST = {1'b0, BASE_ADDR} + 21'(DEPTH - 1);
  localparam logic [8:0]  DEPTH9   = 9'(DEPTH);
  localparam logic [7:0]  DELAY8   = 8'(REPLY_DELAY);

  typedef enum logic [2:0] {
    S_IDLE, S_RX_HDR, S_RX_DATA, S_CHECK, S_WAIT, S_TX_CMD, S_TX_DATA
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  hdr [4];
  logic [7:0]  wbuf [16];
  logic [7:0]  regs [DEPTH];
  logic [4:0]  cnt;
  logic        ovf;
  logic        armed;
  logic [7:0]  wait_cnt;
  logic [7:0]  reply_code;
  logic        has_data;
  logic [3:0]  tx_cnt;
  logic [7:0]  rd_ptr;

  logic [3:0]  cmd;
  logic [19:0] addr;
  logic [7:0]  len;
  logic [7:0]  offset;
  logic        rx_take, is_wr, is_rd, malformed, in_range, nack, commit;

  always_comb begin
    cmd       = hdr[0][7:4];
    addr      = {hdr[0][3:0], hdr[1], hdr[2]};
    len       = hdr[3];
    offset    = addr[7:0] - BASE_ADDR[7:0];
    rx_take   = rx_frame && rx_vld &&
                ((state == S_IDLE && armed) || state == S_RX_HDR || state == S_RX_DATA);
    is_wr     = (cmd == 4'b1000);
    is_rd     = (cmd == 4'b1001);
    malformed = ovf || (cnt < 5'd4) ||
                (is_wr && ({4'd0, cnt} != ({1'b0, len} + 9'd5))) ||
                (is_rd && (cnt != 5'd4));
    // 21-bit sum so a request near the top of the address space cannot wrap into range
    in_range  = (len <= 8'd15) && (addr >= BASE_ADDR) &&
                (({1'b0, addr} + {13'd0, len}) <= WIN_LAST);
    nack      = !(is_wr || is_rd) || !in_range;
    commit    = (state == S_CHECK) && !malformed && !defer_req && !nack && is_wr;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (rx_frame && armed) state_nxt = S_RX_HDR;
      S_RX_HDR:  begin
        if (!rx_frame)                    state_nxt = S_CHECK;
        else if (rx_take && cnt == 5'd3)  state_nxt = S_RX_DATA;
      end
      S_RX_DATA: if (!rx_frame) state_nxt = S_CHECK;
      S_CHECK:   begin
        if (malformed)              state_nxt = S_IDLE;
        else if (REPLY_DELAY == 0)  state_nxt = S_TX_CMD;
        else                        state_nxt = S_WAIT;
      end
      S_WAIT:    if (wait_cnt == 8'd0) state_nxt = S_TX_CMD;
      S_TX_CMD:  state_nxt = S_TX_DATA;
      S_TX_DATA: if (!has_data) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++)     hdr[i]  <= 8'd0;
      for (int i = 0; i < 16; i++)    wbuf[i] <= 8'd0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= 8'd0;
      cnt        <= 5'd0;
      ovf        <= 1'b0;
      armed      <= 1'b0;
      wait_cnt   <= 8'd0;
      reply_code <= 8'd0;
      has_data   <= 1'b0;
      tx_cnt     <= 4'd0;
      rd_ptr     <= 8'd0;
      tx_data    <= 8'd0;
      tx_vld     <= 1'b0;
      tx_frame   <= 1'b0;
    end else begin
      // A new request is accepted only after rx_frame has been seen low while idle
      if (state == S_IDLE && !rx_frame)              armed <= 1'b1;
      else if (state == S_IDLE && rx_frame && armed) armed <= 1'b0;

      if (rx_take) begin
        if (cnt == 5'd20) ovf <= 1'b1;
        else begin
          if (cnt < 5'd4) hdr[cnt[1:0]] <= rx_data;
          else            wbuf[4'(cnt - 5'd4)] <= rx_data;
          cnt <= cnt + 5'd1;
        end
      end else if (state == S_IDLE) begin
        cnt <= 5'd0;
        ovf <= 1'b0;
      end

      for (int j = 0; j < DEPTH; j++) begin
        if (commit && (8'(j) >= offset) && ((8'(j) - offset) <= len))
          regs[j] <= wbuf[4'(8'(j) - offset)];
      end

      case (state)
        S_CHECK: begin
          cnt        <= 5'd0;
          ovf        <= 1'b0;
          wait_cnt   <= DELAY8 - 8'd1;
          reply_code <= defer_req ? 8'h20 : (nack ? 8'h10 : 8'h00);
          has_data   <= !defer_req && !nack && is_rd;
          tx_cnt     <= len[3:0];
          rd_ptr     <= offset;
        end
        S_WAIT: wait_cnt <= wait_cnt - 8'd1;
        S_TX_CMD: begin
          tx_data  <= reply_code;
          tx_vld   <= 1'b1;
          tx_frame <= 1'b1;
        end
        S_TX_DATA: begin
          if (has_data) begin
            tx_data <= regs[rd_ptr[AW-1:0]];
            rd_ptr  <= rd_ptr + 8'd1;
            if (tx_cnt == 4'd0) has_data <= 1'b0;
            else                tx_cnt   <= tx_cnt - 4'd1;
          end else begin
            tx_data  <= 8'd0;
            tx_vld   <= 1'b0;
            tx_frame <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != S_IDLE);
  assign dbg_data = ({1'b0, dbg_addr} < DEPTH9) ? regs[dbg_addr[AW-1:0]] : 8'd0;

endmodule

// File: tb/tb_dp_sink_aux_responder.sv
// Directed bench for dp_sink_aux_responder: table of request/reply vectors plus
// hand-written reset-in-reply and overlapping-frame sequences.
module tb_dp_sink_aux_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       rx_frame;
  logic       defer_req;
  logic [7:0] tx_data;
  logic       tx_vld;
  logic       tx_frame;
  logic       busy;
  logic [7:0] dbg_addr;
  logic [7:0] dbg_data;

  int n_cmp = 0;
  int n_bad = 0;

  dp_sink_aux_responder dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_vld(rx_vld),
    .rx_frame(rx_frame), .defer_req(defer_req), .tx_data(tx_data),
    .tx_vld(tx_vld), .tx_frame(tx_frame), .busy(busy),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    int           nreq;
    logic [191:0] req;
    bit           dfr;
    int           nrep;
    logic [135:0] rep;
  } vec_t;

  vec_t tv [12];
  int   n_tv = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input int nreq, input logic [191:0] req,
                     input bit dfr, input int nrep, input logic [135:0] rep);
    tv[n_tv].name = name; tv[n_tv].nreq = nreq; tv[n_tv].req = req;
    tv[n_tv].dfr = dfr;   tv[n_tv].nrep = nrep; tv[n_tv].rep = rep;
    n_tv++;
  endtask

  // Drives one request frame (random rx_vld gaps) and returns on the edge that samples rx_frame=0
  task automatic send(input int n, input logic [191:0] req, input bit dfr);
    @(negedge clk);
    rx_frame  = 1'b1;
    defer_req = dfr;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rx_vld = 1'b0;
        @(negedge clk);
      end
      rx_data = req[8*(n-1-i) +: 8];
      rx_vld  = 1'b1;
      @(negedge clk);
    end
    rx_vld   = 1'b0;
    rx_frame = 1'b0;
    @(posedge clk);
  endtask

  task automatic collect(input string name, input int nrep, input logic [135:0] rep);
    int lat = 0;
    int got = 0;
    while (!tx_vld && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (nrep == 0) begin
      check({name, "_no_reply"}, {31'd0, tx_vld}, 32'd0);
      check({name, "_busy_idle"}, {31'd0, busy}, 32'd0);
    end else begin
      check({name, "_latency"}, lat, 6);
      while (tx_vld && got < 30) begin
        if (got < nrep) check($sformatf("%s_byte%0d", name, got), {24'd0, tx_data},
                              {24'd0, rep[8*(nrep-1-got) +: 8]});
        check({name, "_frame_hi"}, {31'd0, tx_frame}, 32'd1);
        got++;
        @(posedge clk); #1;
      end
      check({name, "_len"}, got, nrep);
      check({name, "_frame_lo"}, {31'd0, tx_frame}, 32'd0);
      check({name, "_busy_end"}, {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic peek(input logic [7:0] a, input logic [7:0] exp, input string name);
    dbg_addr = a;
    #1;
    check(name, {24'd0, dbg_data}, {24'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0; rx_data = 8'd0; rx_vld = 1'b0; rx_frame = 1'b0;
    defer_req = 1'b0; dbg_addr = 8'd0;

    add("wr_5_3", 7, {8'h80, 8'h00, 8'h05, 8'h02, 8'hAA, 8'hBB, 8'hCC}, 1'b0, 1, {8'h00});
    add("rd_5_3", 4, {8'h90, 8'h00, 8'h05, 8'h02}, 1'b0, 4, {8'h00, 8'hAA, 8'hBB, 8'hCC});
    add("rd_cross", 4, {8'h90, 8'h00, 8'h0E, 8'h03}, 1'b0, 1, {8'h10});
    add("wr_short", 5, {8'h80, 8'h00, 8'h02, 8'h01, 8'h11}, 1'b0, 0, '0);
    add("wr_defer", 6, {8'h80, 8'h00, 8'h02, 8'h01, 8'h11, 8'h22}, 1'b1, 1, {8'h20});
    add("rd_2_2", 4, {8'h90, 8'h00, 8'h02, 8'h01}, 1'b0, 3, {8'h00, 8'h00, 8'h00});
    add("rd_wrap", 4, {8'h9F, 8'hFF, 8'hFF, 8'h01}, 1'b0, 1, {8'h10});
    add("unsup", 4, {8'hA0, 8'h00, 8'h00, 8'h00}, 1'b0, 1, {8'h10});
    add("wr_full", 20, {8'h80, 8'h00, 8'h00, 8'h0F,
                        8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47,
                        8'h48, 8'h49, 8'h4A, 8'h4B, 8'h4C, 8'h4D, 8'h4E, 8'h4F},
        1'b0, 1, {8'h00});
    add("wr_ovf", 21, {8'h80, 8'h00, 8'h00, 8'h0F, {17{8'hEE}}}, 1'b0, 0, '0);
    add("rd_full", 4, {8'h90, 8'h00, 8'h00, 8'h0F}, 1'b0, 17,
        {8'h00, 8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47,
         8'h48, 8'h49, 8'h4A, 8'h4B, 8'h4C, 8'h4D, 8'h4E, 8'h4F});

    #2;
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_tx_vld", {31'd0, tx_vld}, 32'd0);
    check("rst_tx_frame", {31'd0, tx_frame}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    peek(8'd5, 8'h00, "rst_reg5");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int v = 0; v < n_tv; v++) begin
      send(tv[v].nreq, tv[v].req, tv[v].dfr);
      collect(tv[v].name, tv[v].nrep, tv[v].rep);
      defer_req = 1'b0;
      if (v == 0) begin
        peek(8'd5, 8'hAA, "wr_reg5");
        peek(8'd6, 8'hBB, "wr_reg6");
        peek(8'd7, 8'hCC, "wr_reg7");
        peek(8'd8, 8'h00, "wr_reg8_untouched");
      end
      if (v == 2) peek(8'd14, 8'h00, "cross_reg14");
      if (v == 3) check("short_busy", {31'd0, busy}, 32'd0);
      if (v == 4) peek(8'd2, 8'h00, "defer_reg2");
      repeat (2) @(posedge clk);
    end
    peek(8'd20, 8'h00, "dbg_out_of_window");

    // Reset asserted in the middle of a 16-byte read reply
    send(4, {8'h90, 8'h00, 8'h00, 8'h0F}, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("pre_rst_vld", {31'd0, tx_vld}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_vld", {31'd0, tx_vld}, 32'd0);
    check("async_rst_frame", {31'd0, tx_frame}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    for (int a = 0; a < 16; a++) peek(8'(a), 8'h00, $sformatf("post_rst_reg%0d", a));
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    check("post_rst_idle_vld", {31'd0, tx_vld}, 32'd0);

    // A second frame arriving during WAIT must neither disturb nor follow the reply
    send(6, {8'h80, 8'h00, 8'h00, 8'h01, 8'h33, 8'h44}, 1'b0);
    collect("ov_setup", 1, {8'h00});
    repeat (2) @(posedge clk);
    send(4, {8'h90, 8'h00, 8'h00, 8'h01}, 1'b0);
    fork
      collect("ov_reply", 3, {8'h00, 8'h33, 8'h44});
      begin
        repeat (2) @(negedge clk);
        rx_frame = 1'b1;
        for (int i = 0; i < 14; i++) begin
          rx_vld  = (i < 5);
          rx_data = (i == 0) ? 8'h80 : ((i == 4) ? 8'h55 : 8'h00);
          @(negedge clk);
        end
        rx_vld   = 1'b0;
        rx_frame = 1'b0;
      end
    join
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (tx_vld || busy) seen++;
      end
      check("ov_dropped", seen, 0);
    end
    peek(8'd0, 8'h33, "ov_reg0");
    peek(8'd1, 8'h44, "ov_reg1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
